// File: rtl/dmem_responder.sv
// Data-memory responder: a req/ack load/store slave with WAIT_CYC programmable wait states.
// It uses word storage with byte-enable writes and flags misaligned accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WAIT_CYC   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int unsigned AW    = DEPTH_LOG2 + 2;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [31:0]       rd_word_q;
    logic              ack_q;
    logic              err_q;
    logic              busy_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] idx_c;
    logic                  mis_c;
    logic                  unused_addr_c;

    assign idx_c         = addr_q[AW-1:2];
    assign mis_c         = |addr_q[1:0];
    // Upper address bits alias away and are intentionally dropped.
    assign unused_addr_c = &{1'b0, addr[31:AW]};

    // Transaction sequencer and registered response outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= req;
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr[AW-1:0];
                        wdata_q <= wdata;
                        be_q    <= be;
                        cnt_q   <= CW'(WAIT_CYC);
                        state_q <= (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    ack_q   <= 1'b1;
                    err_q   <= mis_c;
                    rdata_q <= (we_q || mis_c) ? 32'd0 : rd_word_q;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Single-port storage; a reset on the access edge cancels the write.
    always_ff @(posedge clock) begin
        if (state_q == S_ACCESS) begin
            rd_word_q <= mem_q[idx_c];
            if (reset && we_q && !mis_c) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_q[b]) begin
                        mem_q[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;
    assign rdata = rdata_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder answering the pipeline's MEM-stage load/store requests over a req/ack handshake with programmable wait states.
- Replaces the single-cycle data memory when memory latency is more than zero.
- The pipeline is the initiator. It holds its request until ack and stalls meanwhile.
- Word-organised storage with byte-enable writes and misalignment detection.

Parameters:
- DEPTH_LOG2, 10, log2 of word count (1024 words = 4 KiB).
- WAIT_CYC, 2, extra cycles between request acceptance and access (0..15).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- req  in  1  initiator request valid; held high until ack
- we  in  1  1 = store, 0 = load; sampled with req
- addr  in  32  byte address; sampled with req
- wdata  in  32  store data; sampled with req
- be  in  4  byte enables for store (be[0] = bits 7:0); ignored for load
- ack  out  1  one-cycle response strobe
- rdata  out  32  load data; valid when ack=1 and we was 0
- err  out  1  misaligned access flag; valid with ack
- busy  out  1  high from acceptance until the cycle ack is asserted, inclusive

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE; ack=0, err=0, busy=0, rdata=0, wait counter=0.
  - Storage contents are NOT cleared.
  - Reset mid-transaction aborts the transaction. No write happens, even if the access would have occurred that edge.
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - If req=1, latch we/addr/wdata/be and load counter=WAIT_CYC.
  - Go to WAIT if WAIT_CYC>0, otherwise go to ACCESS.
  - busy rises on the edge that leaves IDLE.
- WAIT: decrement the counter each cycle. When the counter reaches 1, go to ACCESS next. WAIT therefore lasts exactly WAIT_CYC cycles.
- ACCESS: perform the memory operation on the latched fields, then go to RESP.
  - Word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses alias modulo 2^(DEPTH_LOG2+2).
  - Store: write only the bytes whose be bit is 1. be=0000 is legal and leaves memory unchanged (still acked).
  - Load: capture the full word into rdata.
  - Misaligned means addr[1:0]!=00. A misaligned access sets err, suppresses any write, and forces rdata to 0.
- RESP:
  - ack=1 for exactly one cycle; err valid; rdata holds the load word (0 for stores and errors).
  - Return to IDLE.
  - ack, err and busy return to 0 the next cycle. rdata keeps its value until the next RESP or reset.
- Latency: with req first high at edge N, ack is high during the cycle after edge N+WAIT_CYC+2. Total is WAIT_CYC+3 cycles from request to ack.
- req is ignored outside IDLE; latched fields do not change if the initiator alters inputs while busy.
- Back-to-back: the initiator lowers req on ack. If req is still high in the IDLE cycle after RESP, it is accepted as a new transaction, so the minimum request spacing is WAIT_CYC+3 cycles.
- Read-after-write: a load following a store to the same word returns the updated data, since the write completes in ACCESS before RESP.
- Reads and writes use one port, so there is never more than one operation in flight.

Test Plan:
1. Reset then store: reset low for 2 cycles. Store addr=0x10, wdata=0xDEADBEEF, be=1111. Then load addr=0x10. Required: ack 5 cycles after each req (WAIT_CYC=2), err=0, load rdata=0xDEADBEEF.
2. Byte enables: with word 0x10 = 0xDEADBEEF, store wdata=0x11223344 with be=0101. Then load 0x10. Required: rdata=0xDE22BE44.
3. Misaligned:
   - Store addr=0x13, be=1111. Required: ack with err=1 and no memory change; a later load 0x10 still returns the previous value.
   - Load addr=0x12. Required: err=1, rdata=0.
4. Aliasing and WAIT_CYC=0 build: store 0x5A5A5A5A at addr=0x1004 (DEPTH_LOG2=10), then load addr=0x0004. Required: rdata=0x5A5A5A5A, ack 3 cycles after req.
5. Reset mid-operation: issue a store to 0x20 and assert reset during WAIT.
   - Required: ack never fires, busy=0 after the reset edge.
   - A later load of 0x20 returns the pre-store value; storage is otherwise intact.
6. Input change while busy and back-to-back:
   - Change addr/wdata while busy. Required: the latched values are used.
   - Keep req high through ack. Required: a second transaction is accepted in the IDLE cycle and ack pulses are spaced exactly WAIT_CYC+3 cycles apart.
